pause_dim_ctrl: RTL and testbench
=================================

# pause_dim_ctrl

Parametrised pause and screen-dim controller sitting between the arcade core's RGB output and `arcade_video` in an arcade top level. It merges a user pause toggle, OSD-open pause and N external level requests (hiscore engine, etc.) into one `pause` signal for the core. After a configurable idle time in user or OSD pause it dims the pixel stream by a programmable right-shift.

## Interface
Parameters:
- `CW`, 2: colour bits per channel; pixel bus is 3*CW bits, {R,G,B}, R in MSBs.
- `NSRC`, 1: number of external pause request inputs (min 1).
- `TW`, 32: dim timer width.
- `DIM_CYCLES`, 32'h68E7780: clk cycles of pause before dimming (10 s at 11 MHz).
- `DIM_SHIFT`, 1: right-shift applied per channel when fully dimmed (1..CW).
- `FADE_CYCLES`, 1100000: cycles per fade step; used only with `PAUSE_DIM_FADE_EN`.

Ports:
- `clk`  in  1  system clock; every register is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_pause`  in  1  raw pause button, level; rising edge toggles user pause.
- `btn_resume`  in  1  any-key resume (start/coin), level; rising edge clears user pause.
- `osd_status`  in  1  OSD open.
- `osd_pause_en`  in  1  OSD open pauses the core.
- `pause_req`  in  NSRC  external level pause requests.
- `rgb_in`  in  3*CW  pixel from core.
- `rgb_out`  out  3*CW  registered, possibly dimmed pixel.
- `pause`  out  1  combined pause to core.
- `pause_user`  out  1  user pause state.
- `dimmed`  out  1  dim active.

## Operation
- Edge detect: `btn_prev`/`res_prev` registers; edge = input & ~prev.
- User pause update per cycle, priority order: resume edge while `pause_user`=1 -> clear; else pause edge -> toggle; else hold. Both edges while paused -> clear; both while running -> set.
- `pause` = `pause_user` | (`osd_status` & `osd_pause_en`) | (|`pause_req`), combinational.
- `idle_pause` = `pause_user` | (`osd_status` & `osd_pause_en`). `pause_req` alone never dims.
- FSM: RUN -> WAIT when `idle_pause`=1; WAIT -> DIM when timer reaches DIM_CYCLES; WAIT/DIM -> RUN when `idle_pause`=0.
  - RUN: timer = 0.
  - WAIT: timer increments by 1 per cycle.
  - DIM: timer saturates, no wrap.
- `dimmed`=1 in DIM only.
- `rgb_out` <= `dimmed` ? each channel >> current shift (zero-filled) : `rgb_in`. Each channel is shifted independently; no carry between channels.
- Without the fade feature, current shift = DIM_SHIFT for the whole of DIM.

## Timing
- Reset values:
  - `pause_user`=0, timer=0, state RUN, `dimmed`=0, `rgb_out`=0.
  - `btn_prev`=1 and `res_prev`=1, so a button held through reset does not trigger an edge.
- Pause edge sampled at edge k: `pause_user` and `pause` are high after edge k.
- `pause_req` and `osd_status` reach `pause` with zero latency.
- `rgb_out` latency: 1 cycle from `rgb_in`, all states.
- Entering WAIT at edge k gives DIM at edge k+DIM_CYCLES; dimmed pixels appear from edge k+DIM_CYCLES+1.
- Unpause at edge u: state RUN, timer 0 and `dimmed` 0 after u; undimmed `rgb_out` after u+1.
- Switching between user and OSD pause with no gap keeps `idle_pause` high: timer continues and is not restarted.
- Reset asserted mid-pause or mid-dim: all state returns to reset values at that edge.

## Configuration
- `PAUSE_DIM_FADE_EN` defined:
  - On entry to DIM, current shift starts at 1.
  - Shift increments every FADE_CYCLES cycles, saturating at DIM_SHIFT.
  - Fade counter is cleared on leaving DIM.
- `PAUSE_DIM_FADE_EN` undefined:
  - Shift is DIM_SHIFT immediately on entry to DIM.
  - No fade counter is synthesised.

## Test plan
Bench parameters: CW=2, DIM_CYCLES=8, DIM_SHIFT=1, rgb_in=6'b111111 unless stated.
- Reset release with `btn_pause` held high -> `pause_user`=0; release then press -> `pause`=1 one edge after press.
- User pause held for 8 cycles -> `dimmed`=1 after the 8th cycle; next cycle `rgb_out`=6'b010101. Press again -> `dimmed`=0 immediately, `rgb_out`=6'b111111 one cycle later.
- `pause_req`[0]=1 for 20 cycles -> `pause`=1 throughout; `dimmed` stays 0.
- Paused, `btn_pause` and `btn_resume` rise together -> `pause_user`=0. Running, same stimulus -> `pause_user`=1.
- `osd_status`=1 with `osd_pause_en`=1 for 4 cycles, then user pause set and OSD closed in the same cycle -> timer continues; dim occurs 8 cycles after the OSD opened. With `osd_pause_en`=0 -> no pause.
- With `PAUSE_DIM_FADE_EN`, DIM_SHIFT=2, FADE_CYCLES=4:
  - On DIM entry -> `rgb_out` 6'b010101.
  - 4 cycles later -> `rgb_out` 6'b000000.
  - Reset asserted mid-fade -> all outputs return to reset values.

Source files
------------

// File: rtl/pause_dim_ctrl.sv
// rtl/pause_dim_ctrl.sv - merges user/OSD/external pause and dims the pixel stream after an idle pause
// Optional gradual fade of the dim shift is enabled by defining PAUSE_DIM_FADE_EN.
module pause_dim_ctrl #(
  parameter int            CW          = 2,
  parameter int            NSRC        = 1,
  parameter int            TW          = 32,
  parameter logic [TW-1:0] DIM_CYCLES  = TW'(32'h68E7780),
  parameter int            DIM_SHIFT   = 1,
  parameter int            FADE_CYCLES = 1100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_pause,
  input  logic              btn_resume,
  input  logic              osd_status,
  input  logic              osd_pause_en,
  input  logic [NSRC-1:0]   pause_req,
  input  logic [3*CW-1:0]   rgb_in,
  output logic [3*CW-1:0]   rgb_out,
  output logic              pause,
  output logic              pause_user,
  output logic              dimmed
);

  typedef enum logic [1:0] {RUN, WAIT, DIM} state_t;

  localparam logic [7:0] MAX_SHIFT = 8'(DIM_SHIFT);

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            btn_prev, res_prev;
  logic            pause_edge, res_edge;
  logic            pause_user_nxt, osd_pause, idle_nxt;
  logic [7:0]      cur_shift;
  logic [3*CW-1:0] rgb_dim;

  assign pause_edge = btn_pause & ~btn_prev;
  assign res_edge   = btn_resume & ~res_prev;
  assign osd_pause  = osd_status & osd_pause_en;
  assign pause      = pause_user | osd_pause | (|pause_req);
  assign dimmed     = (state == DIM);

  always_comb begin
    pause_user_nxt = pause_user;
    if (res_edge && pause_user)
      pause_user_nxt = 1'b0;
    else if (pause_edge)
      pause_user_nxt = ~pause_user;
  end

  // Using the next-cycle idle level lets a same-cycle handover between OSD
  // and user pause keep the timer running, and lets unpause leave DIM at once.
  assign idle_nxt = pause_user_nxt | osd_pause;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      RUN: begin
        timer_nxt = '0;
        if (idle_nxt) state_nxt = WAIT;
      end
      WAIT: begin
        timer_nxt = timer + TW'(1);
        if (timer_nxt >= DIM_CYCLES) state_nxt = DIM;
      end
      DIM: begin
        if (timer != '1) timer_nxt = timer + TW'(1);
      end
      default: begin
        state_nxt = RUN;
        timer_nxt = '0;
      end
    endcase
    if (!idle_nxt) begin
      state_nxt = RUN;
      timer_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      timer      <= '0;
      pause_user <= 1'b0;
      btn_prev   <= 1'b1;
      res_prev   <= 1'b1;
      rgb_out    <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      pause_user <= pause_user_nxt;
      btn_prev   <= btn_pause;
      res_prev   <= btn_resume;
      rgb_out    <= dimmed ? rgb_dim : rgb_in;
    end
  end

`ifdef PAUSE_DIM_FADE_EN
  localparam logic [31:0] FADE_LAST = 32'(FADE_CYCLES - 1);
  logic [31:0] fade_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != DIM) begin
      fade_cnt  <= '0;
      cur_shift <= 8'd1;
    end else if (fade_cnt >= FADE_LAST) begin
      fade_cnt <= '0;
      if (cur_shift < MAX_SHIFT) cur_shift <= cur_shift + 8'd1;
    end else begin
      fade_cnt <= fade_cnt + 32'd1;
    end
  end
`else
  assign cur_shift = MAX_SHIFT;
`endif

  // Channels shift independently so no bits leak between R, G and B.
  always_comb begin
    rgb_dim = '0;
    for (int i = 0; i < 3; i++)
      rgb_dim[i*CW +: CW] = rgb_in[i*CW +: CW] >> cur_shift;
  end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// tb/tb_pause_dim_ctrl.sv - scoreboard bench for pause_dim_ctrl (CW=2, DIM_CYCLES=8)
module tb_pause_dim_ctrl;

  localparam int CW = 2;
`ifdef PAUSE_DIM_FADE_EN
  localparam int DSH = 2;
  localparam logic [5:0] LVL2_RGB = 6'h00;
`else
  localparam int DSH = 1;
  localparam logic [5:0] LVL2_RGB = 6'h15;
`endif

  localparam int S_P = 0, S_PU = 1, S_D = 2, S_RGB = 3;

  logic          clk = 1'b0;
  logic          reset, btn_pause, btn_resume, osd_status, osd_pause_en;
  logic [0:0]    pause_req;
  logic [3*CW-1:0] rgb_in, rgb_out;
  logic          pause, pause_user, dimmed;

  pause_dim_ctrl #(
    .CW(CW), .NSRC(1), .TW(32), .DIM_CYCLES(32'd8), .DIM_SHIFT(DSH), .FADE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_resume(btn_resume),
    .osd_status(osd_status), .osd_pause_en(osd_pause_en), .pause_req(pause_req),
    .rgb_in(rgb_in), .rgb_out(rgb_out), .pause(pause), .pause_user(pause_user),
    .dimmed(dimmed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    int         sig;
    logic [5:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int sig, input logic [5:0] val);
    exp_t e;
    e.cyc = cyc; e.name = name; e.sig = sig; e.val = val;
    q.push_back(e);
  endtask

  function automatic logic [5:0] observe(input int sig);
    case (sig)
      S_P:     return {5'd0, pause};
      S_PU:    return {5'd0, pause_user};
      S_D:     return {5'd0, dimmed};
      default: return rgb_out;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [5:0] got;
      e = q.pop_front();
      got = observe(e.sig);
      n_tests++;
      if (got !== e.val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, got, e.val, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; btn_pause = 1'b1; btn_resume = 1'b0; osd_status = 1'b0;
    osd_pause_en = 1'b1; pause_req = 1'b0; rgb_in = 6'h3f;
    step(); step();
    reset = 1'b0;
    chk("rst_pause_user", S_PU, 6'd0);
    chk("rst_pause", S_P, 6'd0);
    chk("rst_dimmed", S_D, 6'd0);
    chk("rst_rgb", S_RGB, 6'd0);

    // button held through reset must not toggle
    step();
    btn_pause = 1'b0; rgb_in = 6'h2d;
    chk("held_no_edge", S_PU, 6'd0);
    chk("rgb_pass", S_RGB, 6'h3f);
    step();
    btn_pause = 1'b1; rgb_in = 6'h3f;
    chk("rgb_pass2", S_RGB, 6'h2d);
    chk("pause_pre", S_P, 6'd0);
    step();
    btn_pause = 1'b0;
    chk("press_pause", S_P, 6'd1);
    chk("press_user", S_PU, 6'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("wait_dim", S_D, (i == 8) ? 6'd1 : 6'd0);
    end
    step();
    btn_pause = 1'b1;
    chk("dim_rgb", S_RGB, 6'h15);
    step();
    btn_pause = 1'b0;
    chk("undim_now", S_D, 6'd0);
    chk("unpause_user", S_PU, 6'd0);
    step();
    chk("undim_rgb", S_RGB, 6'h3f);

    // external request pauses but never dims
    pause_req = 1'b1;
    chk("req_pause", S_P, 6'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("req_hold", S_P, 6'd1);
      chk("req_nodim", S_D, 6'd0);
    end
    step();
    pause_req = 1'b0;
    chk("req_release", S_P, 6'd0);

    // simultaneous pause/resume edges
    step(); btn_pause = 1'b1;
    step(); btn_pause = 1'b0;
    chk("pu_set", S_PU, 6'd1);
    step(); btn_pause = 1'b1; btn_resume = 1'b1;
    step(); btn_pause = 1'b0; btn_resume = 1'b0;
    chk("both_paused", S_PU, 6'd0);
    step(); btn_pause = 1'b1; btn_resume = 1'b1;
    step(); btn_pause = 1'b0; btn_resume = 1'b0;
    chk("both_running", S_PU, 6'd1);
    step(); btn_resume = 1'b1;
    step(); btn_resume = 1'b0;
    chk("resume_clear", S_PU, 6'd0);
    step(); btn_resume = 1'b1;
    step(); btn_resume = 1'b0;
    chk("resume_running", S_PU, 6'd0);

    // OSD pause handed to user pause without a gap keeps the timer going
    step();
    osd_status = 1'b1; osd_pause_en = 1'b1;
    chk("osd_pause", S_P, 6'd1);
    for (int j = 1; j <= 9; j++) begin
      step();
      if (j == 4) begin osd_status = 1'b0; btn_pause = 1'b1; end
      if (j == 5) btn_pause = 1'b0;
      chk("osd_dim", S_D, (j == 9) ? 6'd1 : 6'd0);
    end
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    chk("osd_undim", S_D, 6'd0);
    chk("osd_user_clear", S_PU, 6'd0);

    step();
    osd_status = 1'b1; osd_pause_en = 1'b0;
    chk("osd_en0_pause", S_P, 6'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("osd_en0_user", S_PU, 6'd0);
      chk("osd_en0_dim", S_D, 6'd0);
    end
    step();
    osd_status = 1'b0; osd_pause_en = 1'b1;

    // dim with a distinct pattern, fade progression, then reset mid-dim
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    chk("f_user", S_PU, 6'd1);
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 8) rgb_in = 6'h26;
      chk("f_dim", S_D, (j == 8) ? 6'd1 : 6'd0);
    end
    step();
    rgb_in = 6'h3f;
    chk("dim_rgb_pat", S_RGB, 6'h11);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("fade_lvl1", S_RGB, 6'h15);
    end
    step();
    reset = 1'b1;
    chk("fade_lvl2", S_RGB, LVL2_RGB);
    step();
    reset = 1'b0;
    chk("mid_rst_user", S_PU, 6'd0);
    chk("mid_rst_pause", S_P, 6'd0);
    chk("mid_rst_dim", S_D, 6'd0);
    chk("mid_rst_rgb", S_RGB, 6'd0);
    step();
    chk("post_rst_rgb", S_RGB, 6'h3f);
    chk("post_rst_dim", S_D, 6'd0);

    step(); step();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
